// File: rtl/mem_ctrl_if.sv
// CPU-side word bus for mem_ctrl: the CPU drives address/data/direction, the
// controller answers with a one-cycle ready strobe and registered read data.
interface mem_ctrl_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    output bus_addr,
    output bus_wdata,
    output bus_we,
    input  bus_rdata,
    input  bus_ready
  );

  modport slave (
    input  bus_addr,
    input  bus_wdata,
    input  bus_we,
    output bus_rdata,
    output bus_ready
  );
endinterface

// File: rtl/mem_ctrl.sv
// Wait-stated word memory controller: on-chip RAM, LED register and a read-only CYCLE counter.
// The CYCLE counter is built only when MEM_CTRL_CYCLE_COUNTER_EN is defined.
module mem_ctrl #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic       clk,
  input  logic       reset,
  mem_ctrl_if.slave  bus,
  output logic [7:0] leds,
  output logic       bus_error
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam logic [3:0] WaitLoad = (WAIT_STATES != 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e        r_state, w_state_d;
  logic [3:0]    r_wait_cnt, w_wait_cnt_d;
  logic [31:0]   r_addr, r_wdata;
  logic          r_we;
  logic          r_ready;
  logic [31:0]   r_rdata;
  logic [7:0]    r_leds;
  logic          r_error;
  logic [31:0]   mem [MEM_WORDS];

  logic          w_idle;
  logic [31:0]   w_acc_addr;
  logic          w_acc_we;
  logic [31:0]   w_acc_cyc;
  logic [AW-1:0] w_acc_idx;
  logic [31:0]   w_rd_val;
  logic          w_err;
  logic          w_wr_ram, w_wr_led;

  function automatic logic is_ram(input logic [31:0] a);
    return (a >> (AW + 2)) == 32'd0;
  endfunction

  function automatic logic is_led(input logic [31:0] a);
    return a[31:2] == 30'h2000_0000;
  endfunction

  function automatic logic is_cyc(input logic [31:0] a);
    return a[31:2] == 30'h2000_0001;
  endfunction

  initial begin
    mem = '{default: '0};
  end

  // In IDLE the live bus is the access; afterwards only the latched copy counts.
  assign w_idle     = (r_state == StIdle);
  assign w_acc_addr = w_idle ? bus.bus_addr : r_addr;
  assign w_acc_we   = w_idle ? bus.bus_we : r_we;
  assign w_acc_idx  = w_acc_addr[AW+1:2];
  assign w_wr_ram   = is_ram(r_addr);
  assign w_wr_led   = is_led(r_addr);

`ifdef MEM_CTRL_CYCLE_COUNTER_EN
  logic [31:0] r_cycle, r_cycle_lat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle     <= '0;
      r_cycle_lat <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_idle) r_cycle_lat <= r_cycle;
    end
  end

  assign w_acc_cyc = w_idle ? r_cycle : r_cycle_lat;
`else
  assign w_acc_cyc = '0;
`endif

  always_comb begin
    w_rd_val = 32'hDEAD_BEEF;
    w_err    = 1'b1;
    if (is_ram(w_acc_addr)) begin
      w_rd_val = mem[w_acc_idx];
      w_err    = 1'b0;
    end else if (is_led(w_acc_addr)) begin
      w_rd_val = {24'h0, r_leds};
      w_err    = 1'b0;
    end else if (is_cyc(w_acc_addr)) begin
      w_rd_val = w_acc_cyc;
      w_err    = w_acc_we;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_wait_cnt_d = r_wait_cnt;
    case (r_state)
      StIdle: begin
        if (WAIT_STATES != 0) begin
          w_state_d    = StWait;
          w_wait_cnt_d = WaitLoad;
        end else begin
          w_state_d = StDone;
        end
      end
      StWait: begin
        if (r_wait_cnt == 4'd0) w_state_d = StDone;
        else w_wait_cnt_d = r_wait_cnt - 4'd1;
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_leds     <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_wait_cnt <= w_wait_cnt_d;
      if (w_idle) begin
        r_addr  <= bus.bus_addr;
        r_we    <= bus.bus_we;
        r_wdata <= bus.bus_wdata;
      end
      r_ready <= (w_state_d == StDone);
      r_rdata <= (w_state_d == StDone) ? w_rd_val : 32'h0;
      if ((w_state_d == StDone) && w_err) r_error <= 1'b1;
      if ((r_state == StDone) && r_we && w_wr_led) r_leds <= r_wdata[7:0];
    end
  end

  // Reset forces IDLE immediately, so an aborted write never reaches the RAM.
  always_ff @(posedge clk) begin
    if ((r_state == StDone) && r_we && w_wr_ram) mem[r_addr[AW+1:2]] <= r_wdata;
  end

  assign bus.bus_ready = r_ready;
  assign bus.bus_rdata = r_rdata;
  assign leds          = r_leds;
  assign bus_error     = r_error;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: vector table, hand sequences and a random run against a
// spec-level model, on a WAIT_STATES=0/16-word instance and a WAIT_STATES=1/1024-word instance.
module tb_mem_ctrl;

  localparam int unsigned MW0 = 16;
  localparam int unsigned MW1 = 1024;
`ifdef MEM_CTRL_CYCLE_COUNTER_EN
  localparam bit CycEn = 1'b1;
`else
  localparam bit CycEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic [7:0] leds0, leds1;
  logic       err0, err1;

  mem_ctrl_if if0 ();
  mem_ctrl_if if1 ();

  mem_ctrl #(.MEM_WORDS(MW0), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
    .clk(clk), .reset(rst0), .bus(if0), .leds(leds0), .bus_error(err0)
  );
  mem_ctrl #(.MEM_WORDS(MW1), .WAIT_STATES(1), .INIT_FILE("")) dut1 (
    .clk(clk), .reset(rst1), .bus(if1), .leds(leds1), .bus_error(err1)
  );

  always #5 clk = ~clk;

  // Elapsed clocks since reset release: the value CYCLE should show in any given cycle.
  logic [31:0] cyc_m [2];
  always @(posedge clk or posedge rst0) if (rst0) cyc_m[0] <= 0; else cyc_m[0] <= cyc_m[0] + 1;
  always @(posedge clk or posedge rst1) if (rst1) cyc_m[1] <= 0; else cyc_m[1] <= cyc_m[1] + 1;

  logic [31:0] ram_m [2][MW1];
  logic [7:0]  leds_m [2];
  logic        err_m [2];
  int          n_tot = 0, n_pass = 0;
  int          cur_w = 1;

  typedef struct packed {
    logic        w;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        use_cyc;
    logic [31:0] exp_rd;
    logic [7:0]  exp_leds;
    logic        exp_err;
  } vec_t;
  vec_t tbl [$];

  function automatic int unsigned mw(input int w); return (w == 0) ? MW0 : MW1; endfunction
  function automatic int ws(input int w); return (w == 0) ? 0 : 1; endfunction
  function automatic logic rdy(input int w); return (w == 0) ? if0.bus_ready : if1.bus_ready; endfunction
  function automatic logic [31:0] rdat(input int w);
    return (w == 0) ? if0.bus_rdata : if1.bus_rdata;
  endfunction
  function automatic logic [7:0] leds_of(input int w); return (w == 0) ? leds0 : leds1; endfunction
  function automatic logic err_of(input int w); return (w == 0) ? err0 : err1; endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  task automatic drive(input int w, input logic [31:0] a, input logic we, input logic [31:0] wd);
    if (w == 0) begin
      if0.bus_addr = a; if0.bus_we = we; if0.bus_wdata = wd;
    end else begin
      if1.bus_addr = a; if1.bus_we = we; if1.bus_wdata = wd;
    end
  endtask

  // Memory-map semantics: returns what the access reads and applies its side effects.
  task automatic model_op(input int w, input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input logic [31:0] cyc, output logic [31:0] exp);
    int unsigned word;
    word = a >> 2;
    if (word < mw(w)) begin
      exp = ram_m[w][word];
      if (we) ram_m[w][word] = wd;
    end else if (word == 32'h2000_0000) begin
      exp = {24'h0, leds_m[w]};
      if (we) leds_m[w] = wd[7:0];
    end else if (word == 32'h2000_0001) begin
      exp = CycEn ? cyc : 32'h0;
      if (we) err_m[w] = 1'b1;
    end else begin
      exp = 32'hDEAD_BEEF;
      err_m[w] = 1'b1;
    end
  endtask

  // Called at a negedge inside the IDLE cycle; returns at the negedge of the next IDLE cycle.
  task automatic access(input int w, input logic [31:0] a, input logic we, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e_done);
    int   n;
    logic got;
    drive(w, a, we, wd);
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (rdy(w)) got = 1'b1;
      else begin
        chk($sformatf("rdata_not_ready w%0d", w), rdat(w), 32'h0);
        drive(w, $urandom, 1'($urandom), $urandom);
      end
    end
    chk($sformatf("latency w%0d a=%08h", w, a), n, ws(w) + 1);
    rd     = rdat(w);
    e_done = err_of(w);
    drive(w, $urandom, 1'($urandom), $urandom);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("ready_width w%0d", w), rdy(w), 1'b0);
    drive(w, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic align(input int w);
    int n;
    n = 0;
    while (!rdy(w) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("align_ready w%0d", w), rdy(w), 1'b1);
    @(posedge clk);
    @(negedge clk);
    cur_w = w;
  endtask

  task automatic do_op(input int w, input logic [31:0] a, input logic we, input logic [31:0] wd,
                       output logic [31:0] rd);
    logic [31:0] exp;
    logic        e_done;
    if (w != cur_w) align(w);
    model_op(w, a, we, wd, cyc_m[w], exp);
    access(w, a, we, wd, rd, e_done);
    chk($sformatf("rdata w%0d a=%08h we=%0b", w, a, we), rd, exp);
    chk($sformatf("err_done w%0d a=%08h", w, a), e_done, err_m[w]);
    chk($sformatf("leds w%0d a=%08h", w, a), leds_of(w), leds_m[w]);
  endtask

  function automatic logic [31:0] rand_addr(input int w);
    logic [31:0] a;
    case ($urandom_range(0, 9))
      6: a = 32'(mw(w) * 4 - 4);
      7: a = 32'h8000_0000;
      8: a = 32'h8000_0004;
      9: begin
        case ($urandom_range(0, 3))
          0:       a = 32'(mw(w) * 4);
          1:       a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
          2:       a = 32'h8000_0008;
          default: a = 32'hFFFF_FFFC;
        endcase
      end
      default: a = 32'($urandom_range(0, 15) * 4);
    endcase
    return a | ($urandom & 32'h3);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, v1, v2, exp, mexp, cyc;
    logic        e_done;

    ram_m = '{default: '0};
    leds_m = '{default: '0};
    err_m  = '{default: '0};
    drive(0, 32'h0, 1'b0, 32'h0);
    drive(1, 32'h0, 1'b0, 32'h0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("reset ready w%0d", w), rdy(w), 1'b0);
      chk($sformatf("reset rdata w%0d", w), rdat(w), 32'h0);
      chk($sformatf("reset leds w%0d", w), leds_of(w), 8'h00);
      chk($sformatf("reset err w%0d", w), err_of(w), 1'b0);
    end
    rst0 = 1'b0;
    rst1 = 1'b0;
    cur_w = 1;

    //          w     addr           we    wdata          cyc   exp_rd         leds   err
    tbl.push_back({1'b1, 32'h0000_0010, 1'b1, 32'h1234_5678, 1'b0, 32'h0,         8'h00, 1'b0});
    tbl.push_back({1'b1, 32'h0000_0010, 1'b0, 32'h0,         1'b0, 32'h1234_5678, 8'h00, 1'b0});
    tbl.push_back({1'b1, 32'h8000_0000, 1'b1, 32'h0000_01A5, 1'b0, 32'h0,         8'hA5, 1'b0});
    tbl.push_back({1'b1, 32'h8000_0000, 1'b0, 32'h0,         1'b0, 32'h0000_00A5, 8'hA5, 1'b0});
    tbl.push_back({1'b1, 32'h8000_0004, 1'b0, 32'h0,         1'b1, 32'h0,         8'hA5, 1'b0});
    tbl.push_back({1'b1, 32'h4000_0000, 1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF, 8'hA5, 1'b1});
    tbl.push_back({1'b1, 32'h8000_0004, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0,         8'hA5, 1'b1});
    tbl.push_back({1'b1, 32'h8000_0004, 1'b0, 32'h0,         1'b1, 32'h0,         8'hA5, 1'b1});
    tbl.push_back({1'b1, 32'h0000_0013, 1'b0, 32'h0,         1'b0, 32'h1234_5678, 8'hA5, 1'b1});
    tbl.push_back({1'b1, 32'h0000_1000, 1'b1, 32'hAAAA_5555, 1'b0, 32'hDEAD_BEEF, 8'hA5, 1'b1});
    tbl.push_back({1'b1, 32'h0000_0000, 1'b0, 32'h0,         1'b0, 32'h0,         8'hA5, 1'b1});
    tbl.push_back({1'b1, 32'h0000_0FFC, 1'b1, 32'h0000_0055, 1'b0, 32'h0,         8'hA5, 1'b1});
    tbl.push_back({1'b1, 32'h0000_0FFC, 1'b0, 32'h0,         1'b0, 32'h0000_0055, 8'hA5, 1'b1});
    tbl.push_back({1'b1, 32'h8000_0000, 1'b1, 32'hFFFF_FF3C, 1'b0, 32'h0000_00A5, 8'h3C, 1'b1});
    tbl.push_back({1'b0, 32'h0000_0000, 1'b1, 32'h1111_1111, 1'b0, 32'h0,         8'h00, 1'b0});
    tbl.push_back({1'b0, 32'h0000_0004, 1'b1, 32'h2222_2222, 1'b0, 32'h0,         8'h00, 1'b0});
    tbl.push_back({1'b0, 32'h0000_0000, 1'b0, 32'h0,         1'b0, 32'h1111_1111, 8'h00, 1'b0});
    tbl.push_back({1'b0, 32'h0000_0004, 1'b0, 32'h0,         1'b0, 32'h2222_2222, 8'h00, 1'b0});
    tbl.push_back({1'b0, 32'h0000_003C, 1'b1, 32'h0000_3C3C, 1'b0, 32'h0,         8'h00, 1'b0});
    tbl.push_back({1'b0, 32'h0000_003C, 1'b0, 32'h0,         1'b0, 32'h0000_3C3C, 8'h00, 1'b0});
    tbl.push_back({1'b0, 32'h0000_0040, 1'b1, 32'h0000_0099, 1'b0, 32'hDEAD_BEEF, 8'h00, 1'b1});
    tbl.push_back({1'b0, 32'h0000_0000, 1'b0, 32'h0,         1'b0, 32'h1111_1111, 8'h00, 1'b1});

    foreach (tbl[i]) begin
      if (int'(tbl[i].w) != cur_w) align(int'(tbl[i].w));
      cyc = cyc_m[tbl[i].w];
      model_op(int'(tbl[i].w), tbl[i].addr, tbl[i].we, tbl[i].wdata, cyc, mexp);
      exp = tbl[i].use_cyc ? (CycEn ? cyc : 32'h0) : tbl[i].exp_rd;
      access(int'(tbl[i].w), tbl[i].addr, tbl[i].we, tbl[i].wdata, rd, e_done);
      chk($sformatf("vec%0d rdata", i), rd, exp);
      chk($sformatf("vec%0d err", i), e_done, tbl[i].exp_err);
      chk($sformatf("vec%0d leds", i), leds_of(int'(tbl[i].w)), tbl[i].exp_leds);
    end

    // Reset in the middle of a write's WAIT cycle must abort it.
    do_op(1, 32'h0000_0020, 1'b1, 32'hCAFE_F00D, rd);
    drive(1, 32'h0000_0020, 1'b1, 32'h0BAD_BAD0);
    @(posedge clk);
    @(negedge clk);
    rst1 = 1'b1;
    #1;
    chk("midreset ready", rdy(1), 1'b0);
    chk("midreset rdata", rdat(1), 32'h0);
    chk("midreset leds", leds_of(1), 8'h00);
    chk("midreset err", err_of(1), 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    drive(1, 32'h0, 1'b0, 32'h0);
    leds_m[1] = 8'h00;
    err_m[1]  = 1'b0;
    do_op(1, 32'h0000_0020, 1'b0, 32'h0, rd);
    chk("midreset old value kept", rd, 32'hCAFE_F00D);

    // Two CYCLE reads five back-to-back accesses (ten clocks) apart.
    do_op(0, 32'h8000_0004, 1'b0, 32'h0, v1);
    for (int k = 0; k < 4; k++) do_op(0, 32'h0, 1'b0, 32'h0, rd);
    do_op(0, 32'h8000_0004, 1'b0, 32'h0, v2);
    chk("cycle delta", v2 - v1, CycEn ? 32'd10 : 32'd0);
    if (!CycEn) chk("cycle read zero", v1, 32'h0);

    for (int w = 1; w >= 0; w--) begin
      for (int k = 0; k < 150; k++) begin
        do_op(w, rand_addr(w), 1'($urandom), $urandom, rd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, giving the on-chip word memory depth in 32-bit words (power of two).
REQ-002 The block SHALL have parameter WAIT_STATES, default 1, giving the extra cycles inserted per access (0..15).
REQ-003 The block SHALL have parameter INIT_FILE, default "" (empty), naming a hex file loaded into memory at elaboration; when empty, memory contents SHALL be zero.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port bus_addr, input, 32 bits: byte address from the CPU.
REQ-007 The block SHALL have port bus_wdata, input, 32 bits: write data.
REQ-008 The block SHALL have port bus_we, input, 1 bit: 1 means write, 0 means read.
REQ-009 The block SHALL have port bus_rdata, output, 32 bits: read data, valid only while bus_ready=1.
REQ-010 The block SHALL have port bus_ready, output, 1 bit: access-complete strobe.
REQ-011 The block SHALL have port leds, output, 8 bits: LED register contents.
REQ-012 The block SHALL have port bus_error, output, 1 bit: sticky unmapped-access flag.

Function
REQ-013 The memory map SHALL be:
- RAM at 0x0000_0000 .. MEM_WORDS*4-1, read/write.
- LED register at 0x8000_0000, read/write; bits [7:0] are used and bits [31:8] read 0.
- CYCLE counter at 0x8000_0004, read-only.
- Everything else is unmapped.
REQ-014 bus_addr[1:0] SHALL be ignored; all accesses are whole 32-bit words.
REQ-015 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-016 In IDLE, the block SHALL latch bus_addr, bus_we and bus_wdata, then go to WAIT if WAIT_STATES>0, else to DONE.
REQ-017 WAIT SHALL last exactly WAIT_STATES cycles, counted by an internal down-counter, then go to DONE.
REQ-018 DONE SHALL last one cycle, with bus_ready=1 and bus_rdata driven from the latched address; the FSM SHALL then go to IDLE.
REQ-019 bus_ready and bus_rdata SHALL be registered, Moore-style outputs.
REQ-020 bus_rdata SHALL be 0 whenever bus_ready=0.
REQ-021 Access latency from the IDLE sample to bus_ready SHALL be WAIT_STATES+1 cycles; the per-access period SHALL be WAIT_STATES+2 cycles.
REQ-022 A write SHALL update RAM or the LED register at the clock edge that ends DONE.
REQ-023 The bus_rdata returned during a write access SHALL be the pre-write value of the target.
REQ-024 Input changes during WAIT or DONE SHALL be ignored; only values latched in IDLE are used.
REQ-025 An unmapped read SHALL return 0xDEAD_BEEF.
REQ-026 An unmapped write, or any write to CYCLE, SHALL be discarded.
REQ-027 Any unmapped access, or any write to CYCLE, SHALL set bus_error in its DONE cycle; bus_error SHALL stay set until reset.
REQ-028 Every access, including an error access, SHALL complete with bus_ready; the block SHALL never stall indefinitely.
REQ-029 A RAM word index SHALL be bus_addr[31:2]; any address at or above MEM_WORDS*4 in the low region SHALL be unmapped, with no aliasing.

Reset
REQ-030 Asserting reset SHALL immediately force:
- state=IDLE;
- bus_ready=0;
- bus_rdata=0;
- leds=0x00;
- bus_error=0;
- CYCLE=0;
- wait counter=0.
REQ-031 Reset SHALL NOT clear RAM contents.
REQ-032 Reset asserted mid-access SHALL abort the access; a pending write SHALL NOT be committed.
REQ-033 After reset deasserts, the first clock edge SHALL sample in IDLE.

Configuration
REQ-034 The macro MEM_CTRL_CYCLE_COUNTER_EN SHALL control the CYCLE counter.
REQ-035 When MEM_CTRL_CYCLE_COUNTER_EN is defined, CYCLE SHALL be a 32-bit free-running counter that increments every cycle outside reset and wraps from 0xFFFF_FFFF to 0.
REQ-036 A CYCLE read SHALL return the counter value captured in the IDLE cycle of that access.
REQ-037 When MEM_CTRL_CYCLE_COUNTER_EN is undefined, no counter SHALL be built, and 0x8000_0004 SHALL read 0 and still be treated as read-only, with no error on reads.

Verification
REQ-038 With WAIT_STATES=1, write 0x1234_5678 to 0x10, then read 0x10 -> each access has bus_ready high for exactly 1 cycle, 2 cycles after IDLE; the read returns 0x1234_5678.
REQ-039 Write 0x0000_01A5 to 0x8000_0000 -> leds=0xA5 after DONE; a read of 0x8000_0000 returns 0x0000_00A5.
REQ-040 Read 0x4000_0000, then write 0x8000_0004 -> the read returns 0xDEAD_BEEF; bus_error rises on the first DONE and stays 1; the counter is unchanged.
REQ-041 With WAIT_STATES=0, do back-to-back reads of 0x0 and 0x4 -> bus_ready pulses every 2nd cycle with the correct data; toggling bus_addr mid-access has no effect.
REQ-042 Assert reset during WAIT of a write to 0x20 -> bus_ready=0 and leds=0 immediately; a later read of 0x20 returns the old value.
REQ-043 With MEM_CTRL_CYCLE_COUNTER_EN defined, do two CYCLE reads 10 cycles apart -> the values differ by 10; with the macro undefined, both reads return 0.
